// File: rtl/yarc_pkg.sv
// Shared encodings for the memory-access stage: op-class bits, width bits, FSM states.
package yarc_pkg;

    // Bit positions inside the one-hot ex_mem_instype vector
    localparam int IT_R     = 0;
    localparam int IT_I     = 1;
    localparam int IT_ST    = 2;
    localparam int IT_LD    = 3;
    localparam int IT_BR    = 4;
    localparam int IT_LUI   = 5;
    localparam int IT_AUIPC = 6;
    localparam int IT_JAL   = 7;
    localparam int IT_JALR  = 8;

    // Bit positions inside the one-hot ex_mem_subtype vector
    localparam int SUB_SB  = 0;
    localparam int SUB_SH  = 1;
    localparam int SUB_SW  = 2;
    localparam int SUB_LB  = 0;
    localparam int SUB_LH  = 1;
    localparam int SUB_LW  = 2;
    localparam int SUB_LBU = 3;
    localparam int SUB_LHU = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, alignment check for requests, and
// shift/extend of the returned word for loads.
module mem_align
    import yarc_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [4:0]  req_sub,
    input  logic        is_store,
    input  logic        is_load,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    input  logic [1:0]  rd_off,
    input  logic [4:0]  rd_sub,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the ifs can infer a latch.
        wstrb      = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        if (is_store) begin
            if (req_sub[SUB_SB]) begin
                wstrb = 4'b0001 << req_off;
                wdata = {4{st_data[7:0]}};
            end else if (req_sub[SUB_SH]) begin
                wstrb      = req_off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{st_data[15:0]}};
                misaligned = req_off[0];
            end else if (req_sub[SUB_SW]) begin
                wstrb      = 4'b1111;
                wdata      = st_data;
                misaligned = |req_off;
            end
        end else if (is_load) begin
            misaligned = ((req_sub[SUB_LH] | req_sub[SUB_LHU]) & req_off[0])
                       | (req_sub[SUB_LW] & (|req_off));
        end
    end

    // Bring the addressed byte/half down to bit 0, then extend to 32 bits
    always_comb begin
        shifted = rdata >> {rd_off, 3'b000};
        ld_data = 32'h0;
        if (rd_sub[SUB_LB])       ld_data = {{24{shifted[7]}}, shifted[7:0]};
        else if (rd_sub[SUB_LH])  ld_data = {{16{shifted[15]}}, shifted[15:0]};
        else if (rd_sub[SUB_LW])  ld_data = shifted;
        else if (rd_sub[SUB_LBU]) ld_data = {24'h0, shifted[7:0]};
        else if (rd_sub[SUB_LHU]) ld_data = {16'h0, shifted[15:0]};
    end

endmodule

// File: rtl/memunit.sv
// Memory-access pipeline stage: issues data-memory requests, waits for ready
// (with timeout), and produces a registered writeback bundle.
module memunit
    import yarc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [8:0]  ex_mem_instype,
    input  logic [7:0]  ex_mem_subtype,
    input  logic [31:0] ex_mem_aluout1,
    input  logic [31:0] ex_mem_aluout2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        mem_wb_valid,
    output logic        mem_wb_we,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            ld_q;
    logic [4:0]      sub_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;

    logic        is_st, is_ld, is_mem, rf_wr_op;
    logic [4:0]  ex_rd;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, ld_data;
    logic        al_mis, issue, timeout_hit;
    logic        unused_sub;

    assign is_st    = ex_mem_instype[IT_ST];
    assign is_ld    = ex_mem_instype[IT_LD];
    assign is_mem   = is_st | is_ld;
    assign rf_wr_op = ex_mem_instype[IT_R] | ex_mem_instype[IT_I]
                    | ex_mem_instype[IT_LUI] | ex_mem_instype[IT_AUIPC];
    assign ex_rd    = ex_mem_aluout2[4:0];
    assign unused_sub = &ex_mem_subtype[7:5];

    mem_align u_align (
        .req_off    (ex_mem_aluout1[1:0]),
        .req_sub    (ex_mem_subtype[4:0]),
        .is_store   (is_st),
        .is_load    (is_ld),
        .st_data    (ex_mem_aluout2),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .misaligned (al_mis),
        .rd_off     (off_q),
        .rd_sub     (sub_q),
        .rdata      (dmem_rdata),
        .ld_data    (ld_data)
    );

    assign issue       = (state == S_IDLE) & ex_mem_valid & is_mem & ~al_mis;
    assign timeout_hit = (state == S_WAIT) && (cnt == TO_W'(TIMEOUT - 1));
    assign stall       = issue | ((state == S_WAIT) & ~dmem_ready & ~timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ld_q         <= 1'b0;
            sub_q        <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wstrb   <= '0;
            dmem_wdata   <= '0;
            mem_wb_valid <= 1'b0;
            mem_wb_we    <= 1'b0;
            mem_wb_rd    <= '0;
            mem_wb_data  <= '0;
            misaligned   <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads pre-edge values; pulses default low here.
            mem_wb_valid <= 1'b0;
            misaligned   <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_mem_valid) begin
                        if (!is_mem) begin
                            mem_wb_valid <= 1'b1;
                            mem_wb_we    <= rf_wr_op && (ex_rd != 5'd0);
                            mem_wb_rd    <= ex_rd;
                            mem_wb_data  <= ex_mem_aluout1;
                        end else if (al_mis) begin
                            misaligned   <= 1'b1;
                            mem_wb_valid <= 1'b1;
                            mem_wb_we    <= 1'b0;
                            mem_wb_rd    <= is_ld ? ex_rd : 5'd0;
                            mem_wb_data  <= '0;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_st;
                            dmem_addr  <= {ex_mem_aluout1[31:2], 2'b00};
                            dmem_wstrb <= al_wstrb;
                            dmem_wdata <= al_wdata;
                            ld_q       <= is_ld;
                            sub_q      <= ex_mem_subtype[4:0];
                            off_q      <= ex_mem_aluout1[1:0];
                            rd_q       <= is_ld ? ex_rd : 5'd0;
                            cnt        <= '0;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Ready in the timeout cycle still counts as a normal completion
                    if (dmem_ready) begin
                        dmem_req     <= 1'b0;
                        state        <= S_IDLE;
                        mem_wb_valid <= 1'b1;
                        mem_wb_rd    <= rd_q;
                        mem_wb_we    <= ld_q && (rd_q != 5'd0);
                        mem_wb_data  <= ld_q ? ld_data : 32'h0;
                    end else if (timeout_hit) begin
                        dmem_req     <= 1'b0;
                        state        <= S_IDLE;
                        bus_err      <= 1'b1;
                        mem_wb_valid <= 1'b1;
                        mem_wb_we    <= 1'b0;
                        mem_wb_rd    <= rd_q;
                        mem_wb_data  <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memunit.sv
// Scoreboard bench for memunit: stimulus pushes expected requests/writebacks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_memunit;

    logic        clk;
    logic        rst;
    logic        ex_mem_valid;
    logic [8:0]  ex_mem_instype;
    logic [7:0]  ex_mem_subtype;
    logic [31:0] ex_mem_aluout1;
    logic [31:0] ex_mem_aluout2;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        mem_wb_valid;
    logic        mem_wb_we;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        misaligned;
    logic        bus_err;

    memunit #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_mem_valid   (ex_mem_valid),
        .ex_mem_instype (ex_mem_instype),
        .ex_mem_subtype (ex_mem_subtype),
        .ex_mem_aluout1 (ex_mem_aluout1),
        .ex_mem_aluout2 (ex_mem_aluout2),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_we      (mem_wb_we),
        .mem_wb_rd      (mem_wb_rd),
        .mem_wb_data    (mem_wb_data),
        .misaligned     (misaligned),
        .bus_err        (bus_err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        logic        chk_rd;
        logic        chk_data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    req_exp_t cur_req;
    bit       req_active;
    int       checks;
    int       errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of each queue
    always @(negedge clk) begin
        if (rst) begin
            req_active = 1'b0;
        end else begin
            if (dmem_req) begin
                if (!req_active) begin
                    if (req_q.size() == 0) check("unexpected_req", 96'(dmem_req), 96'd0);
                    else begin
                        cur_req    = req_q.pop_front();
                        req_active = 1'b1;
                    end
                end
                if (req_active)
                    check("dmem_fields", {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata},
                          {cur_req.we, cur_req.addr, cur_req.wstrb, cur_req.wdata});
            end else begin
                req_active = 1'b0;
            end
            if (mem_wb_valid) begin
                if (wb_q.size() == 0) check("unexpected_wb", 96'(mem_wb_valid), 96'd0);
                else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    check("wb_we_mis_berr", {mem_wb_we, misaligned, bus_err}, {e.we, e.mis, e.berr});
                    if (e.chk_rd)   check("wb_rd", 96'(mem_wb_rd), 96'(e.rd));
                    if (e.chk_data) check("wb_data", 96'(mem_wb_data), 96'(e.data));
                end
            end else if (misaligned || bus_err) begin
                check("orphan_pulse", {misaligned, bus_err}, 2'b00);
            end
        end
    end

    task automatic idle_inputs();
        ex_mem_valid   = 1'b0;
        ex_mem_instype = '0;
        ex_mem_subtype = '0;
        ex_mem_aluout1 = '0;
        ex_mem_aluout2 = '0;
    endtask

    task automatic push_wb(input logic we, input logic [4:0] rd, input logic [31:0] data,
                           input logic mis, input logic berr, input logic chk_rd, input logic chk_data);
        wb_exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.mis = mis; e.berr = berr;
        e.chk_rd = chk_rd; e.chk_data = chk_data;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
        req_exp_t r;
        r.we = we; r.addr = addr; r.wstrb = wstrb; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    // Non-memory op; dmem_ready is held high to show it is ignored in IDLE
    task automatic nonmem(input logic [8:0] it, input logic [31:0] a1, input logic [31:0] a2,
                          input logic exp_we);
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_instype = it; ex_mem_subtype = '0;
        ex_mem_aluout1 = a1; ex_mem_aluout2 = a2; dmem_ready = 1'b1;
        push_wb(exp_we, a2[4:0], a1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("nonmem_stall", 96'(stall), 96'd0);
    endtask

    // Aligned memory op, ready after n_wait WAIT cycles without it
    task automatic mem_op(input bit st, input int sub, input logic [31:0] addr, input logic [31:0] a2,
                          input logic [31:0] rdata, input int n_wait,
                          input logic [31:0] e_addr, input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                          input logic e_wb_we, input logic [31:0] e_data);
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_instype = st ? 9'h004 : 9'h008;
        ex_mem_subtype = 8'(1 << sub); ex_mem_aluout1 = addr; ex_mem_aluout2 = a2;
        dmem_ready = 1'b0;
        push_req(st, e_addr, e_wstrb, e_wdata);
        push_wb(e_wb_we, a2[4:0], e_data, 1'b0, 1'b0, !st, 1'b1);
        #1 check("issue_stall", 96'(stall), 96'd1);
        @(posedge clk); #1;
        for (int i = 0; i < n_wait; i++) begin
            check("wait_stall", 96'(stall), 96'd1);
            @(posedge clk); #1;
        end
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #1 check("done_stall", 96'(stall), 96'd0);
        @(posedge clk); #1;
        dmem_ready = 1'b0; dmem_rdata = '0;
        idle_inputs();
    endtask

    task automatic misaligned_op(input bit st, input int sub, input logic [31:0] addr);
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_instype = st ? 9'h004 : 9'h008;
        ex_mem_subtype = 8'(1 << sub); ex_mem_aluout1 = addr; ex_mem_aluout2 = 32'h4;
        dmem_ready = 1'b0;
        push_wb(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("mis_stall", 96'(stall), 96'd0);
        @(posedge clk); #1;
        check("mis_no_req", {misaligned, dmem_req}, 2'b10);
        idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0; req_active = 1'b0;
        rst = 1'b1; dmem_ready = 1'b0; dmem_rdata = '0;
        idle_inputs();
        #1;
        check("reset_outputs",
              {dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, stall,
               mem_wb_valid, mem_wb_we, mem_wb_rd, misaligned, bus_err}, '0);
        check("reset_wb_data", 96'(mem_wb_data), 96'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Pass-through ops, including rd=0 and non-writing classes
        nonmem(9'h001, 32'h0000_1234, 32'd5,  1'b1);
        nonmem(9'h002, 32'h0000_0055, 32'd0,  1'b0);
        nonmem(9'h010, 32'h0000_0099, 32'd7,  1'b0);
        nonmem(9'h020, 32'hABCD_0000, 32'd31, 1'b1);
        nonmem(9'h080, 32'h0000_0104, 32'd1,  1'b0);

        // Stores: lane steering and replication
        mem_op(1, 0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 2, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0);
        mem_op(1, 1, 32'h0000_0502, 32'h0000_1234, 32'h0, 0, 32'h0000_0500, 4'b1100, 32'h1234_1234, 1'b0, 32'h0);
        mem_op(1, 2, 32'h0000_0700, 32'hCAFE_F00D, 32'h0, 1, 32'h0000_0700, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);

        // Loads: sign and zero extension from various offsets
        mem_op(0, 0, 32'h0000_0202, 32'd7, 32'h0080_0000, 0, 32'h0000_0200, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80);
        mem_op(0, 3, 32'h0000_0202, 32'd7, 32'h0080_0000, 0, 32'h0000_0200, 4'b0000, 32'h0, 1'b1, 32'h0000_0080);
        mem_op(0, 1, 32'h0000_0302, 32'd8, 32'h8001_0000, 1, 32'h0000_0300, 4'b0000, 32'h0, 1'b1, 32'hFFFF_8001);
        mem_op(0, 4, 32'h0000_0302, 32'd8, 32'h8001_0000, 0, 32'h0000_0300, 4'b0000, 32'h0, 1'b1, 32'h0000_8001);
        mem_op(0, 0, 32'h0000_0201, 32'd0, 32'h0000_7F00, 0, 32'h0000_0200, 4'b0000, 32'h0, 1'b0, 32'h0000_007F);

        // Misaligned accesses: no request, one pulse
        misaligned_op(0, 1, 32'h0000_0301);
        misaligned_op(1, 2, 32'h0000_0501);

        // Timeout: LW never answered, bus_err 16 edges after issue
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_instype = 9'h008; ex_mem_subtype = 8'h04;
        ex_mem_aluout1 = 32'h0000_0400; ex_mem_aluout2 = 32'd3; dmem_ready = 1'b0;
        push_req(1'b0, 32'h0000_0400, 4'b0000, 32'h0);
        push_wb(1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("to_issue_stall", 96'(stall), 96'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            check("to_wait_stall", 96'(stall), 96'd1);
            @(posedge clk); #1;
        end
        check("to_last_cycle", {stall, bus_err, dmem_req}, 3'b001);
        @(posedge clk); #1;
        check("to_bus_err", {bus_err, dmem_req}, 2'b10);
        idle_inputs();

        // Reset in the middle of a store's WAIT
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_instype = 9'h004; ex_mem_subtype = 8'h04;
        ex_mem_aluout1 = 32'h0000_0500; ex_mem_aluout2 = 32'hDEAD_BEEF;
        push_req(1'b1, 32'h0000_0500, 4'b1111, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("pre_rst_req", 96'(dmem_req), 96'd1);
        @(negedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, stall,
               mem_wb_valid, mem_wb_we, mem_wb_rd, misaligned, bus_err}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("no_retry", 96'(dmem_req), 96'd0);
        mem_op(0, 2, 32'h0000_0600, 32'd9, 32'h1234_5678, 1, 32'h0000_0600, 4'b0000, 32'h0, 1'b1, 32'h1234_5678);

        // Let the monitor drain, bounded
        for (int i = 0; i < 20 && (wb_q.size() != 0 || req_q.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("wb_q_drained", 96'(wb_q.size()), 96'd0);
        check("req_q_drained", 96'(req_q.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
